// File: rtl/pong_game_sequencer.sv
// Match-level controller for Pong: holds/serves/runs the ball, keeps both
// scores, alternates serve direction and paces delays in video frames.
// Every output is a flop loaded from the next-state logic, so all o_* move
// together on the edge that samples the triggering input.
// o_state exposes the FSM encoding for debug LEDs and checkers.
module pong_game_sequencer #(
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int WIN_SCORE    = 9,
  parameter int SCORE_W      = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_frame_tick,
  input  logic               i_start,
  input  logic               i_miss1,
  input  logic               i_miss2,
  output logic               o_ball_run,
  output logic               o_ball_center,
  output logic               o_serve_dir,
  output logic [SCORE_W-1:0] o_score1,
  output logic [SCORE_W-1:0] o_score2,
  output logic               o_game_over,
  output logic               o_winner,
  output logic [2:0]         o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic               r_start_prev;
  logic               r_ball_run;
  logic               r_ball_center;
  logic               r_serve_dir;
  logic [SCORE_W-1:0] r_score1;
  logic [SCORE_W-1:0] r_score2;
  logic               r_game_over;
  logic               r_winner;

  state_t             w_next_state;
  logic [CNT_W-1:0]   w_next_count;
  logic               w_next_dir;
  logic [SCORE_W-1:0] w_next_score1;
  logic [SCORE_W-1:0] w_next_score2;
  logic               w_start_edge;

  // Previous-start register resets high so a button held through reset is not an edge.
  assign w_start_edge = i_start & ~r_start_prev;

  // Next-state, score, serve-direction and frame-count logic.
  always_comb begin
    w_next_state  = r_state;
    w_next_count  = r_count;
    w_next_dir    = r_serve_dir;
    w_next_score1 = r_score1;
    w_next_score2 = r_score2;
    case (r_state)
      S_IDLE, S_OVER: begin
        if (w_start_edge) begin
          w_next_score1 = '0;
          w_next_score2 = '0;
          w_next_dir    = 1'b1;
          w_next_state  = S_SERVE;
        end
      end
      S_SERVE: begin
        if (i_frame_tick) begin
          if (r_count == SERVE_LAST) w_next_state = S_PLAY;
          else                       w_next_count = r_count + CNT_W'(1);
        end
      end
      S_PLAY: begin
        // A miss always wins over a tick; ticks are not counted in PLAY anyway.
        if (i_miss1 && i_miss2) begin
          w_next_dir   = ~r_serve_dir;
          w_next_state = S_POINT;
        end else if (i_miss1) begin
          if (r_score2 < WIN) w_next_score2 = r_score2 + SCORE_W'(1);
          w_next_dir   = 1'b0;
          w_next_state = S_POINT;
        end else if (i_miss2) begin
          if (r_score1 < WIN) w_next_score1 = r_score1 + SCORE_W'(1);
          w_next_dir   = 1'b1;
          w_next_state = S_POINT;
        end
      end
      S_POINT: begin
        if (i_frame_tick) begin
          if (r_count == POINT_LAST) begin
            if (r_score1 == WIN || r_score2 == WIN) w_next_state = S_OVER;
            else                                    w_next_state = S_SERVE;
          end else begin
            w_next_count = r_count + CNT_W'(1);
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
    // Any transition discards the in-flight frame count, so an entry-edge tick never counts.
    if (w_next_state != r_state) w_next_count = '0;
  end

  // State, counters and registered outputs; reset has priority over start edges.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_start_prev  <= 1'b1;
      r_ball_run    <= 1'b0;
      r_ball_center <= 1'b1;
      r_serve_dir   <= 1'b0;
      r_score1      <= '0;
      r_score2      <= '0;
      r_game_over   <= 1'b0;
      r_winner      <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_count       <= w_next_count;
      r_start_prev  <= i_start;
      r_ball_run    <= (w_next_state == S_PLAY);
      r_ball_center <= (w_next_state != S_PLAY) && (w_next_state != S_POINT);
      r_serve_dir   <= w_next_dir;
      r_score1      <= w_next_score1;
      r_score2      <= w_next_score2;
      r_game_over   <= (w_next_state == S_OVER);
      r_winner      <= (w_next_state == S_OVER) && (w_next_score2 == WIN);
    end
  end

  assign o_ball_run    = r_ball_run;
  assign o_ball_center = r_ball_center;
  assign o_serve_dir   = r_serve_dir;
  assign o_score1      = r_score1;
  assign o_score2      = r_score2;
  assign o_game_over   = r_game_over;
  assign o_winner      = r_winner;
  assign o_state       = r_state;

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Directed bench for pong_game_sequencer with SERVE=2, POINT=3, WIN=3 frames/points.
module tb_pong_game_sequencer;

  localparam int SCORE_W = 4;

  logic               i_clk;
  logic               i_reset;
  logic               i_frame_tick;
  logic               i_start;
  logic               i_miss1;
  logic               i_miss2;
  logic               o_ball_run;
  logic               o_ball_center;
  logic               o_serve_dir;
  logic [SCORE_W-1:0] o_score1;
  logic [SCORE_W-1:0] o_score2;
  logic               o_game_over;
  logic               o_winner;
  logic [2:0]         o_state;

  int n_checks = 0;
  int n_fails  = 0;

  pong_game_sequencer #(
    .SERVE_FRAMES(2),
    .POINT_FRAMES(3),
    .WIN_SCORE   (3),
    .SCORE_W     (SCORE_W)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_frame_tick (i_frame_tick),
    .i_start      (i_start),
    .i_miss1      (i_miss1),
    .i_miss2      (i_miss2),
    .o_ball_run   (o_ball_run),
    .o_ball_center(o_ball_center),
    .o_serve_dir  (o_serve_dir),
    .o_score1     (o_score1),
    .o_score2     (o_score2),
    .o_game_over  (o_game_over),
    .o_winner     (o_winner),
    .o_state      (o_state)
  );

  // Clock generation
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Single comparison point for every check
  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fails++;
      $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Full output snapshot
  task automatic check_all(input string tag, input int st, input int center, input int run,
                           input int dir, input int s1, input int s2, input int go, input int win);
    check({tag, "_state"},  32'(o_state),       st);
    check({tag, "_center"}, 32'(o_ball_center), center);
    check({tag, "_run"},    32'(o_ball_run),    run);
    check({tag, "_dir"},    32'(o_serve_dir),   dir);
    check({tag, "_s1"},     32'(o_score1),      s1);
    check({tag, "_s2"},     32'(o_score2),      s2);
    check({tag, "_over"},   32'(o_game_over),   go);
    check({tag, "_win"},    32'(o_winner),      win);
  endtask

  // One clock with current inputs, then clear single-cycle pulses; outputs sampled #1 after the edge
  task automatic step();
    @(posedge i_clk);
    #1;
    i_frame_tick = 1'b0;
    i_miss1      = 1'b0;
    i_miss2      = 1'b0;
  endtask

  // n frame ticks, each followed by an idle cycle
  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      i_frame_tick = 1'b1;
      step();
      step();
    end
  endtask

  task automatic start_edge();
    i_start = 1'b0;
    step();
    i_start = 1'b1;
    step();
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b1; i_frame_tick = 1'b0; i_miss1 = 1'b0; i_miss2 = 1'b0;
    step(); step();
    check_all("reset", 0, 1, 0, 0, 0, 0, 0, 0);

    // Start held through reset is not an edge
    i_reset = 1'b0;
    step(); step();
    check_all("held_start", 0, 1, 0, 0, 0, 0, 0, 0);

    // Start edge with a tick on the entry edge (must not count)
    i_start = 1'b0;
    step();
    i_start = 1'b1; i_frame_tick = 1'b1;
    step();
    check_all("serve_entry", 1, 1, 0, 1, 0, 0, 0, 0);
    ticks(1);
    check("serve_after1", 32'(o_state), 1);
    // Miss and start edge ignored in SERVE
    i_miss1 = 1'b1;
    step();
    start_edge();
    check_all("serve_ignore", 1, 1, 0, 1, 0, 0, 0, 0);
    ticks(1);
    check_all("play1", 2, 0, 1, 1, 0, 0, 0, 0);

    // miss2 with a simultaneous tick: miss wins
    i_miss2 = 1'b1; i_frame_tick = 1'b1;
    step();
    check_all("point_p1", 3, 0, 0, 1, 1, 0, 0, 0);
    ticks(2);
    check("point_hold", 32'(o_state), 3);
    ticks(1);
    check_all("serve2", 1, 1, 0, 1, 1, 0, 0, 0);
    ticks(2);
    check("play2", 32'(o_state), 2);

    // Both miss together: no score, direction toggles 1 -> 0
    i_miss1 = 1'b1; i_miss2 = 1'b1;
    step();
    check_all("both_miss", 3, 0, 0, 0, 1, 0, 0, 0);
    ticks(3); ticks(2);
    check("play3", 32'(o_state), 2);

    // Player 2 to three points
    i_miss1 = 1'b1; step();
    check_all("p2_1", 3, 0, 0, 0, 1, 1, 0, 0);
    ticks(3); ticks(2);
    i_miss1 = 1'b1; step();
    check("p2_2", 32'(o_score2), 2);
    ticks(3); ticks(2);
    i_miss1 = 1'b1; step();
    check_all("p2_3", 3, 0, 0, 0, 1, 3, 0, 0);
    ticks(3);
    check_all("over", 4, 1, 0, 0, 1, 3, 1, 1);
    i_miss1 = 1'b1; step();
    i_miss2 = 1'b1; step();
    check_all("over_miss", 4, 1, 0, 0, 1, 3, 1, 1);
    start_edge();
    check_all("restart", 1, 1, 0, 1, 0, 0, 0, 0);

    // Reset mid-POINT with count at 2
    ticks(2);
    i_miss2 = 1'b1; step();
    check("point_p1b", 32'(o_score1), 1);
    ticks(2);
    i_reset = 1'b1; i_frame_tick = 1'b1;
    step();
    check_all("mid_reset", 0, 1, 0, 0, 0, 0, 0, 0);
    i_reset = 1'b0;
    ticks(1);
    check_all("post_reset", 0, 1, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pong_game_sequencer.md
# pong_game_sequencer

Match-level controller for the Pong datapath: decides when the ball is centred, held or running, keeps both players' scores, and alternates serve direction. It sits between the debounced controls and the ball/paddle renderers and is clocked by the PLL pixel clock. It paces serve and point delays in whole video frames using a frame-tick pulse from the VGA sync logic. It produces the run/centre/direction controls that the ball logic consumes.

## Interface
- SERVE_FRAMES, 60: frames the ball is held at centre before each serve (≥1)
- POINT_FRAMES, 90: frames the ball is frozen after a point (≥1)
- WIN_SCORE, 9: score that ends the match (1..15)
- SCORE_W, 4: score counter width
- i_clk  in  1  pixel clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_frame_tick  in  1  one-cycle pulse per frame (start of vertical blank)
- i_start  in  1  debounced start level, active-high; rising edge detected internally
- i_miss1  in  1  pulse: ball passed paddle 1 (left edge); player 2 scores
- i_miss2  in  1  pulse: ball passed paddle 2 (right edge); player 1 scores
- o_ball_run  out  1  ball may move
- o_ball_center  out  1  ball forced to screen centre
- o_serve_dir  out  1  0 = serve toward paddle 1 (left), 1 = toward paddle 2 (right)
- o_score1, o_score2  out  SCORE_W  player scores
- o_game_over  out  1  match finished
- o_winner  out  1  0 = player 1, 1 = player 2; valid while o_game_over
- o_state  out  3  current state encoding (debug/LED)

## Operation
- States: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4; all other codes go to IDLE next cycle.
- Start edge = i_start high && registered previous i_start low. The previous-value register resets to 1, so a button held through reset does not start a match.
- IDLE: center=1, run=0. Start edge → scores cleared, serve_dir=1, → SERVE.
- SERVE: center=1, run=0. Counts i_frame_tick. The SERVE_FRAMES-th tick → PLAY.
- PLAY: center=0, run=1.
  - i_miss1 alone → score2+1, serve_dir=0, → POINT.
  - i_miss2 alone → score1+1, serve_dir=1, → POINT.
  - Both in the same cycle → no score change, serve_dir toggles, → POINT.
- POINT: center=0, run=0 (ball frozen). The POINT_FRAMES-th tick → OVER if either score == WIN_SCORE, else → SERVE.
- OVER: game_over=1, center=1, run=0. winner=1 iff score2 == WIN_SCORE. Start edge → scores cleared, serve_dir=1, → SERVE.
- Miss pulses are ignored outside PLAY. Start edges are ignored in SERVE, PLAY and POINT.
- Scores saturate at WIN_SCORE; no wrap.
- Frame counter is wide enough for max(SERVE_FRAMES, POINT_FRAMES). It clears on every state transition and counts only ticks sampled while the registered state is SERVE or POINT.

## Timing
- All outputs are registered; o_* change on the clock edge that samples the triggering input (one-cycle latency).
- Reset values: state IDLE, o_ball_center=1, o_ball_run=0, o_serve_dir=0, scores 0, o_game_over=0, o_winner=0, counter 0.
- Reset mid-match (any state) → all of the above on the next edge; in-flight counts are discarded.
- A tick sampled on the same edge a state is entered is not counted. SERVE therefore lasts exactly SERVE_FRAMES ticks after entry.
- On a miss edge, o_ball_run falls and the score updates on the same edge. No intermediate cycle shows a run ball with a new score.
- A tick and a miss in the same PLAY cycle: the miss wins and the tick is discarded.
- An i_start edge coinciding with i_reset is ignored.

## Test plan
Bench parameters: SERVE_FRAMES=2, POINT_FRAMES=3, WIN_SCORE=3.
- Reset with i_start held high, then release reset → stays IDLE, center=1, run=0. Drop and re-raise i_start → SERVE, scores 0/0, serve_dir=1.
- In SERVE, deliver 2 ticks → run=1 one cycle after the 2nd tick. A tick on the SERVE entry edge does not count.
- In PLAY, pulse i_miss2 → next edge score1=1, run=0, serve_dir=1, state=3. After 3 ticks → SERVE; 2 more ticks → PLAY.
- In PLAY, pulse i_miss1 and i_miss2 together → scores unchanged, serve_dir toggled, state=POINT.
- Drive player 2 to 3 points via i_miss1 → after POINT expires, state=OVER, game_over=1, winner=1, score2=3. Further misses do not change the score. A start edge → 0/0, SERVE.
- Assert i_reset mid-POINT with count at 2 → next edge all reset values. A later tick does not advance the state.
